// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall, flush and forwarding control for the five-stage core
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemProtoErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] MemWaitCycles
);

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  mem_state_e mem_state_q, mem_state_d;
  logic       mem_proto_err_q, mem_proto_err_d;
  logic       lw_stall;
  logic       mem_stall;

  // Memory stage result is younger than Writeback, so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd_sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd_sel = 2'b01;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemReqM & ~MemReadyM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state_q     <= MEM_IDLE;
      mem_proto_err_q <= 1'b0;
    end else begin
      mem_state_q     <= mem_state_d;
      mem_proto_err_q <= mem_proto_err_d;
    end
  end

  always_comb begin
    mem_state_d     = mem_state_q;
    mem_proto_err_d = mem_proto_err_q;
    case (mem_state_q)
      MEM_IDLE: begin
        if (mem_stall) begin
          mem_state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          mem_state_d = MEM_IDLE;
        end else if (!MemReqM) begin
          // Requester abandoned an access the memory had not finished.
          mem_state_d     = MEM_IDLE;
          mem_proto_err_d = 1'b1;
        end
      end
      default: mem_state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      StallF    = lw_stall | mem_stall;
      StallD    = lw_stall | mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushW    = mem_stall;
      // Pending redirects and load-use bubbles wait until memory releases the pipe.
      FlushE    = ~mem_stall & (lw_stall | PCSrcE);
      FlushD    = ~mem_stall & PCSrcE;
    end
  end

  assign MemProtoErr = mem_proto_err_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [CNT_W-1:0] mem_wait_cycles_q, mem_wait_cycles_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    sat_inc = (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  always_comb begin
    stall_cycles_d    = sat_inc(stall_cycles_q, StallF);
    flush_count_d     = sat_inc(flush_count_q, FlushD | FlushE);
    mem_wait_cycles_d = sat_inc(mem_wait_cycles_q, mem_stall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      flush_count_q     <= '0;
      mem_wait_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      flush_count_q     <= flush_count_d;
      mem_wait_cycles_q <= mem_wait_cycles_d;
    end
  end

  assign StallCycles   = stall_cycles_q;
  assign FlushCount    = flush_count_q;
  assign MemWaitCycles = mem_wait_cycles_q;
`else
  assign StallCycles   = '0;
  assign FlushCount    = '0;
  assign MemWaitCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized bench for hazard_controller against a behavioural model
module tb_hazard_controller;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemProtoErr;
  logic [CNT_W-1:0] StallCycles, FlushCount, MemWaitCycles;

  int n_vec = 0;
  int n_err = 0;

  // Model: whether an access is outstanding past its first cycle, sticky error, event counts.
  bit m_busy, m_err;
  int m_stall, m_flush, m_mwait;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemProtoErr(MemProtoErr),
    .StallCycles(StallCycles), .FlushCount(FlushCount), .MemWaitCycles(MemWaitCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input bit en);
    return (en && v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_stall = 0; m_flush = 0; m_mwait = 0;
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Inputs are already driven (after a negedge); checks everything, then clocks the model.
  task automatic cycle();
    bit ms, lw, sf, fd, fe;
    int ec, ef, ew;
    #1;
    ms = MemReqM && !MemReadyM;
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (reset) begin
      check("rst_fwdA", 32'(ForwardAE), 0);
      check("rst_fwdB", 32'(ForwardBE), 0);
      check("rst_stalls", {StallF, StallD, StallE, StallM}, 0);
      check("rst_flushes", {FlushD, FlushE, FlushW}, 3'b111);
      sf = 0; fd = 1; fe = 1;
    end else begin
      sf = lw || ms;
      fd = !ms && PCSrcE;
      fe = !ms && (PCSrcE || lw);
      check("fwdA", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
      check("fwdB", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
      check("stallFD", {StallF, StallD}, {sf, sf});
      check("stallEM", {StallE, StallM}, {ms, ms});
      check("flushD", 32'(FlushD), 32'(fd));
      check("flushE", 32'(FlushE), 32'(fe));
      check("flushW", 32'(FlushW), 32'(ms));
    end
    check("proto_err", 32'(MemProtoErr), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    ec = m_stall; ef = m_flush; ew = m_mwait;
`else
    ec = 0; ef = 0; ew = 0;
`endif
    check("cnt_stall", 32'(StallCycles), ec);
    check("cnt_flush", 32'(FlushCount), ef);
    check("cnt_mwait", 32'(MemWaitCycles), ew);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_stall = sat(m_stall, sf);
      m_flush = sat(m_flush, fd || fe);
      m_mwait = sat(m_mwait, ms);
      if (!m_busy) begin
        if (ms) m_busy = 1;
      end else if (MemReadyM) begin
        m_busy = 0;
      end else if (!MemReqM) begin
        m_busy = 0;
        m_err  = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    cycle();
    reset = 0;
  endtask

  int  se_cnt;
  bit  busy;
  int  rem;

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    // Reset must mask live hazards on the inputs.
    RegWriteM = 1; RdM = 5; Rs1E = 5; MemReqM = 1; PCSrcE = 1;
    cycle();
    do_reset();

    // Forwarding priority.
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #1;
    check("tp_fwdA_mem", 32'(ForwardAE), 32'(2'b10));
    check("tp_fwdB_x0", 32'(ForwardBE), 32'(2'b00));
    cycle();
    RegWriteM = 0;
    #1;
    check("tp_fwdA_wb", 32'(ForwardAE), 32'(2'b01));
    cycle();

    // Load-use.
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    check("tp_lw", {StallF, StallD, FlushE, FlushD, StallE}, 5'b11100);
    cycle();
    RdE = 0;
    #1;
    check("tp_lw_x0", {StallF, StallD, FlushE}, 3'b000);
    cycle();

    // Three wait cycles from a fresh reset.
    do_reset();
    se_cnt = 0;
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      MemReadyM = 0;
      #1;
      if (StallE && StallM && StallF && StallD && FlushW) se_cnt++;
      cycle();
    end
    MemReadyM = 1;
    #1;
    if (StallE) se_cnt++;
    cycle();
    idle_inputs();
    check("tp_wait_len", se_cnt, 3);
`ifdef HAZARD_PERF_CNT_EN
    check("tp_mwait_cnt", 32'(MemWaitCycles), 3);
`else
    check("tp_mwait_cnt", 32'(MemWaitCycles), 0);
`endif
    cycle();

    // Branch held behind a two-cycle wait.
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      MemReadyM = 0;
      #1;
      check("tp_br_held", {FlushD, FlushE}, 2'b00);
      cycle();
    end
    MemReadyM = 1;
    #1;
    check("tp_br_release", {FlushD, FlushE}, 2'b11);
    cycle();
    idle_inputs();

    // Protocol violation, then asynchronous reset mid-wait.
    MemReqM = 1; MemReadyM = 0;
    cycle();
    MemReqM = 0;
    cycle();
    check("tp_proto_set", 32'(MemProtoErr), 1);
    for (int i = 0; i < 3; i++) cycle();
    check("tp_proto_sticky", 32'(MemProtoErr), 1);
    MemReqM = 1; MemReadyM = 0;
    cycle();
    #2;
    reset = 1;
    model_reset();
    #1;
    check("tp_async_rst", 32'(MemProtoErr), 0);
    @(negedge clk);
    idle_inputs();
    cycle();
    reset = 0;
    // If the FSM were still in WAIT, this would raise the error.
    MemReqM = 0; MemReadyM = 0;
    cycle();
    cycle();
    check("tp_idle_after_rst", 32'(MemProtoErr), 0);

    // Saturation under a long stall.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 20; i++) cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("tp_sat", 32'(StallCycles), CNT_MAX);
`else
    check("tp_sat", 32'(StallCycles), 0);
`endif
    MemReadyM = 1;
    cycle();

    // Randomized traffic.
    busy = 0; rem = 0;
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 0) begin
        busy = 0;
        do_reset();
      end
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 3) == 0);
      if (!busy && $urandom_range(0, 2) == 0) begin
        busy = 1;
        rem  = $urandom_range(0, 3);
      end
      if (busy) begin
        MemReqM   = 1;
        MemReadyM = (rem == 0);
        if (rem == 0) busy = 0;
        else rem--;
        if (!MemReadyM && $urandom_range(0, 39) == 0) begin
          MemReqM = 0;
          busy    = 0;
        end
      end else begin
        MemReqM   = 0;
        MemReadyM = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
